alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
//  Upstream feeder for the ALU_in bus. Buffers ALU commands from a producer
//  in a small FIFO. Issues each command onto the ALU_in signals (alu_rst,
//  valid, op, a, b) under the ALU's ready handshake.
//  Sits between the test/host command source and the ALU DUT input port.
//  Each command is either an operation or an ALU reset request.
// PARAMETERS
//  ALU_IN_OP_WIDTH  8  width of operands a/b and cmd_a/cmd_b
//  FIFO_DEPTH       4  command FIFO entries; power of 2, >=2
//  RST_CYCLES       2  cycles alu_rst is held low per reset command; >=1
// PORTS
//  clk          in   1        clock; all logic on posedge
//  rst          in   1        synchronous reset, active-low
//  cmd_valid    in   1        producer command valid
//  cmd_ready    out  1        FIFO can accept (=!full)
//  cmd_kind     in   1        0=operation, 1=ALU reset request
//  cmd_op       in   3        opcode (alu_op_t)
//  cmd_a        in   OPW      operand a
//  cmd_b        in   OPW      operand b
//  alu_rst      out  1        ALU reset, active-low, registered
//  ready        in   1        ALU ready to accept an operation
//  valid        out  1        operation valid to ALU, registered
//  op           out  3        opcode to ALU, registered
//  a            out  OPW      operand a to ALU, registered
//  b            out  OPW      operand b to ALU, registered
//  fifo_count   out  clog2(D)+1  entries currently buffered
//  busy         out  1        state!=IDLE or fifo_count!=0
// BEHAVIOUR
//  - Reset (rst==0 at posedge): FIFO emptied, state IDLE, valid=0, op=0,
//    a=0, b=0, alu_rst=1, fifo_count=0. cmd_valid ignored while rst==0.
//    Reset mid-operation aborts it: buffered commands dropped, alu_rst
//    returns to 1 on that edge.
//  - Push on posedge when cmd_valid&&cmd_ready. No bypass: a command
//    accepted at edge N drives valid or alu_rst no earlier than edge N+1.
//  - Full: cmd_ready=0. A pop in the same cycle does not raise cmd_ready
//    until the next cycle. Count changes by +1, -1, or 0 on push+pop.
//  - FSM states: IDLE, ISSUE, GAP, ARST.
//    IDLE: if FIFO is non-empty and head is an operation, load op/a/b and
//          set valid=1 -> ISSUE. If head is a reset request, set alu_rst=0
//          and load the counter -> ARST.
//    ISSUE: valid, op, a and b are held stable until ready==1 at a posedge.
//           On that edge: pop, valid<=0 -> GAP.
//    GAP: one mandatory bubble cycle with valid=0 -> IDLE. Minimum spacing
//         is 1 issue per 3 cycles.
//    ARST: alu_rst=0 for exactly RST_CYCLES cycles, with valid=0 throughout.
//          Then pop, alu_rst<=1 -> GAP.
//  - ready is ignored outside ISSUE. op/a/b keep their last issued value
//    when valid=0.
//  - All opcodes, including 3'b000 no_op, are issued unchanged. There is no
//    arithmetic on a/b.
// CONFIGURATION
//  ALU_ISSUE_STATS_EN defined: adds outputs issued_count[15:0], counting
//    ISSUE transfers, and rst_count[15:0], counting completed ARST.
//    Both saturate at 16'hFFFF and clear on rst.
//  Undefined: neither port nor counter exists. All other behaviour is
//    identical.
// STRUCTURE
//  alu_issue_pkg contents:
//    typedef enum logic[2:0] alu_op_t {no_op, add_op, and_op, xor_op, mul_op}
//    typedef enum issuer_state_t {IDLE, ISSUE, GAP, ARST}
//    struct alu_cmd_t {kind, op, a, b}
//  Sub-module alu_cmd_fifo: parameterised sync FIFO of alu_cmd_t, exposing
//    push/pop/full/empty/count. The FSM and output registers stay in the
//    top module.
// TESTING
//  1. rst=0 for 3 cycles, then 1 -> valid=0, alu_rst=1, op/a/b=0,
//     fifo_count=0, cmd_ready=1, busy=0.
//  2. Push add_op a=8'h05 b=8'h03 with ready=1 -> valid=1 for exactly 1
//     cycle starting the edge after the push, op=3'b001 a=05 b=03, then
//     fifo_count=0.
//  3. Same op with ready=0 for 5 cycles -> valid/op/a/b held stable. The
//     transfer occurs on the first ready=1 edge, then a 1-cycle GAP.
//  4. ready=0, push 5 commands back-to-back -> cmd_ready=0 after the 4th
//     push, 5th not accepted, fifo_count=4. Drain in FIFO order.
//  5. Sequence op, reset request, op -> alu_rst low exactly 2 cycles,
//     valid=0 during ARST; second op issued after the GAP.
//  6. With ALU_ISSUE_STATS_EN: 3 ops + 1 reset request -> issued_count=3,
//     rst_count=1. Then rst=0 mid-ISSUE -> counters 0, FIFO empty, valid=0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU command issuer: opcodes, FSM states, command payload.
// Operand width is fixed here because the command struct carries the operands.
package alu_issue_pkg;

  localparam int unsigned ALU_IN_OP_WIDTH = 8;
  localparam int unsigned ALU_OPC_WIDTH   = 3;
  localparam logic        KIND_OP         = 1'b0;
  localparam logic        KIND_RST        = 1'b1;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    ARST  = 2'd3
  } issuer_state_t;

  // op is kept as a raw 3-bit field so undefined encodings pass through untouched
  typedef struct packed {
    logic                       kind;
    logic [ALU_OPC_WIDTH-1:0]   op;
    logic [ALU_IN_OP_WIDTH-1:0] a;
    logic [ALU_IN_OP_WIDTH-1:0] b;
  } alu_cmd_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of alu_cmd_t with first-word head view, occupancy count
// and synchronous active-low reset. DEPTH must be a power of two, >= 2.
module alu_cmd_fifo
  import alu_issue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  alu_cmd_t      push_data,
  input  logic          pop,
  output alu_cmd_t      head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  alu_cmd_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands and issues them onto the ALU_in bus under ready handshake.
// Optional macro ALU_ISSUE_STATS_EN adds saturating issued_count / rst_count outputs.
module alu_cmd_issuer
  import alu_issue_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 4,
  parameter  int unsigned RST_CYCLES = 2,
  localparam int unsigned OPW        = ALU_IN_OP_WIDTH,
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_kind,
  input  logic [ALU_OPC_WIDTH-1:0] cmd_op,
  input  logic [OPW-1:0]           cmd_a,
  input  logic [OPW-1:0]           cmd_b,
  output logic                     alu_rst,
  input  logic                     ready,
  output logic                     valid,
  output logic [ALU_OPC_WIDTH-1:0] op,
  output logic [OPW-1:0]           a,
  output logic [OPW-1:0]           b,
  output logic [CW-1:0]            fifo_count,
  output logic                     busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]              issued_count,
  output logic [15:0]              rst_count
`endif
);

  localparam int unsigned RCW = $clog2(RST_CYCLES + 1);

  issuer_state_t            state;
  issuer_state_t            state_n;
  logic                     valid_n;
  logic [ALU_OPC_WIDTH-1:0] op_n;
  logic [OPW-1:0]           a_n;
  logic [OPW-1:0]           b_n;
  logic                     alu_rst_n;
  logic [RCW-1:0]           rcnt;
  logic [RCW-1:0]           rcnt_n;

  alu_cmd_t cmd_in;
  alu_cmd_t head;
  logic     push;
  logic     pop;
  logic     full;
  logic     empty;

  assign cmd_in    = '{kind: cmd_kind, op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE) || (fifo_count != '0);

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cmd_in),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // Next-state and next-output logic; the head entry is popped only once fully handled
  always_comb begin
    state_n   = state;
    valid_n   = valid;
    op_n      = op;
    a_n       = a;
    b_n       = b;
    alu_rst_n = alu_rst;
    rcnt_n    = rcnt;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          if (head.kind == KIND_RST) begin
            alu_rst_n = 1'b0;
            rcnt_n    = RCW'(RST_CYCLES - 1);
            state_n   = ARST;
          end else begin
            valid_n = 1'b1;
            op_n    = head.op;
            a_n     = head.a;
            b_n     = head.b;
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (ready) begin
          pop     = 1'b1;
          valid_n = 1'b0;
          state_n = GAP;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      ARST: begin
        if (rcnt == '0) begin
          pop       = 1'b1;
          alu_rst_n = 1'b1;
          state_n   = GAP;
        end else begin
          rcnt_n = rcnt - RCW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      valid   <= 1'b0;
      op      <= '0;
      a       <= '0;
      b       <= '0;
      alu_rst <= 1'b1;
      rcnt    <= '0;
    end else begin
      state   <= state_n;
      valid   <= valid_n;
      op      <= op_n;
      a       <= a_n;
      b       <= b_n;
      alu_rst <= alu_rst_n;
      rcnt    <= rcnt_n;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  // Event counters: one per accepted transfer, one per completed reset pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      issued_count <= '0;
      rst_count    <= '0;
    end else begin
      if (state == ISSUE && ready)      issued_count <= sat_inc16(issued_count);
      if (state == ARST && rcnt == '0)  rst_count    <= sat_inc16(rst_count);
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: accepted commands queue up in order and a
// negedge monitor checks each ALU transfer / reset pulse against the queue head.
`timescale 1ns/1ps
module tb_alu_cmd_issuer;

  localparam int unsigned RSTC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_kind;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       alu_rst;
  logic       ready;
  logic       valid;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] fifo_count;
  logic       busy;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issued_count;
  logic [15:0] rst_count;
`endif

  always #5 clk = ~clk;

  alu_cmd_issuer #(
    .FIFO_DEPTH (4),
    .RST_CYCLES (RSTC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_kind   (cmd_kind),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_rst    (alu_rst),
    .ready      (ready),
    .valid      (valid),
    .op         (op),
    .a          (a),
    .b          (b),
    .fifo_count (fifo_count),
    .busy       (busy)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .issued_count (issued_count),
    .rst_count    (rst_count)
`endif
  );

  typedef struct {
    logic       kind;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  cmd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: anything offered and accepted at this edge joins the expected stream
  task automatic tick();
    bit   acc;
    cmd_t c;
    acc = rst && cmd_valid && cmd_ready;
    c   = '{cmd_kind, cmd_op, cmd_a, cmd_b};
    @(posedge clk);
    if (acc) exp_q.push_back(c);
    #1;
  endtask

  task automatic set_cmd(input logic k, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    cmd_valid = 1'b1;
    cmd_kind  = k;
    cmd_op    = o;
    cmd_a     = x;
    cmd_b     = y;
  endtask

  task automatic push_cmd(input logic k, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    bit done;
    done = 0;
    set_cmd(k, o, x, y);
    for (int i = 0; i < 200 && !done; i++) begin
      done = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!done) check("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    exp_q.delete();
    repeat (n) tick();
    rst = 1'b1;
  endtask

  task automatic drain();
    ready     = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 500 && (exp_q.size() != 0 || busy); i++) tick();
    check("drain_queue_empty", 32'(exp_q.size()), 32'(0));
    check("drain_idle", 32'(busy), 32'(0));
  endtask

  // Monitor: transfers, hold-stable, reset pulse length and issue spacing
  initial begin : monitor
    int         low_len;
    int         since;
    bit         hold;
    logic [18:0] held;
    cmd_t       e;
    low_len = 0;
    since   = 100;
    hold    = 0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        low_len = 0;
        since   = 100;
        hold    = 0;
      end else begin
        if (since < 100) since++;
        if (!alu_rst) begin
          if (low_len == 0) begin
            check("arst_spacing", 32'(since >= 3), 32'(1));
            check("arst_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("arst_kind", 32'(e.kind), 32'(1));
            end
          end
          check("valid_during_arst", 32'(valid), 32'(0));
          low_len++;
        end else if (low_len != 0) begin
          check("arst_len", 32'(low_len), 32'(RSTC));
          low_len = 0;
          since   = 1;
        end
        if (valid && hold) check("hold_stable", 32'({op, a, b}), 32'(held));
        hold = valid && !ready;
        held = {op, a, b};
        if (valid && ready) begin
          check("issue_spacing", 32'(since >= 3), 32'(1));
          since = 0;
          check("issue_expected", 32'(exp_q.size() != 0), 32'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("issue_kind", 32'(e.kind), 32'(0));
            check("issue_op", 32'(op), 32'(e.op));
            check("issue_a", 32'(a), 32'(e.a));
            check("issue_b", 32'(b), 32'(e.b));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [2:0] ops [5];
    rst       = 1'b0;
    ready     = 1'b0;
    cmd_valid = 1'b0;
    cmd_kind  = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;

    // Reset state
    do_reset(3);
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_alu_rst", 32'(alu_rst), 32'(1));
    check("rst_op", 32'(op), 32'(0));
    check("rst_a", 32'(a), 32'(0));
    check("rst_b", 32'(b), 32'(0));
    check("rst_count", 32'(fifo_count), 32'(0));
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));

    // Single add with ready high: valid for exactly one cycle, edge after push
    ready = 1'b1;
    set_cmd(1'b0, 3'b001, 8'h05, 8'h03);
    tick();
    cmd_valid = 1'b0;
    check("nobypass_valid", 32'(valid), 32'(0));
    check("push_count", 32'(fifo_count), 32'(1));
    tick();
    check("add_valid", 32'(valid), 32'(1));
    check("add_op", 32'(op), 32'(3'b001));
    check("add_a", 32'(a), 32'(8'h05));
    check("add_b", 32'(b), 32'(8'h03));
    tick();
    check("add_valid_drop", 32'(valid), 32'(0));
    check("add_count_zero", 32'(fifo_count), 32'(0));
    drain();

    // Held by ready low for 5 cycles, then one transfer and a bubble
    ready = 1'b0;
    push_cmd(1'b0, 3'b001, 8'h05, 8'h03);
    for (int i = 0; i < 10 && !valid; i++) tick();
    check("stall_valid_up", 32'(valid), 32'(1));
    repeat (5) begin
      tick();
      check("stall_hold", 32'({valid, op, a, b}), 32'({1'b1, 3'b001, 8'h05, 8'h03}));
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("stall_gap", 32'(valid), 32'(0));
    check("stall_count", 32'(fifo_count), 32'(0));
    drain();

    // Fill the FIFO with ready low; fifth push refused
    ready  = 1'b0;
    ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b011; ops[3] = 3'b100; ops[4] = 3'b000;
    for (int i = 0; i < 5; i++) begin
      set_cmd(1'b0, ops[i], 8'(i * 17 + 1), 8'(8'hA0 + i));
      check("fill_cmd_ready", 32'(cmd_ready), 32'(i < 4 ? 1 : 0));
      tick();
    end
    cmd_valid = 1'b0;
    check("full_count", 32'(fifo_count), 32'(4));
    check("full_cmd_ready", 32'(cmd_ready), 32'(0));
    drain();

    // op, reset request, op
    ready = 1'b1;
    push_cmd(1'b0, 3'b011, 8'h11, 8'h22);
    push_cmd(1'b1, 3'b000, 8'h00, 8'h00);
    push_cmd(1'b0, 3'b100, 8'h33, 8'h44);
    drain();

    // Reset in the middle of an ALU reset pulse
    ready = 1'b0;
    push_cmd(1'b1, 3'b000, 8'h00, 8'h00);
    push_cmd(1'b0, 3'b010, 8'h55, 8'h66);
    for (int i = 0; i < 10 && alu_rst; i++) tick();
    check("arst_entered", 32'(alu_rst), 32'(0));
    do_reset(1);
    check("abort_alu_rst", 32'(alu_rst), 32'(1));
    check("abort_count", 32'(fifo_count), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));

`ifdef ALU_ISSUE_STATS_EN
    do_reset(2);
    ready = 1'b1;
    push_cmd(1'b0, 3'b001, 8'h01, 8'h02);
    push_cmd(1'b1, 3'b000, 8'h00, 8'h00);
    push_cmd(1'b0, 3'b010, 8'h03, 8'h04);
    push_cmd(1'b0, 3'b011, 8'h05, 8'h06);
    drain();
    check("stats_issued", 32'(issued_count), 32'(3));
    check("stats_rst", 32'(rst_count), 32'(1));
    ready = 1'b0;
    push_cmd(1'b0, 3'b100, 8'h07, 8'h08);
    for (int i = 0; i < 10 && !valid; i++) tick();
    check("stats_mid_issue", 32'(valid), 32'(1));
    do_reset(1);
    check("stats_issued_clr", 32'(issued_count), 32'(0));
    check("stats_rst_clr", 32'(rst_count), 32'(0));
    check("stats_fifo_clr", 32'(fifo_count), 32'(0));
    check("stats_valid_clr", 32'(valid), 32'(0));
`endif

    // Randomized traffic with one asynchronous-to-traffic reset mid-run
    do_reset(2);
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == 300) do_reset(1);
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_kind  = ($urandom_range(0, 5) == 0);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      ready     = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
